// File: rtl/cycle_motion.sv
// rtl/cycle_motion.sv - light-cycle motion, crash detection and game state machine
module cycle_motion #(
  parameter int ARENA_W = 600,
  parameter int ARENA_H = 600,
  parameter int STEP    = 1,
  parameter int P1_X0   = 6,
  parameter int P1_Y0   = 594,
  parameter int P2_X0   = 594,
  parameter int P2_Y0   = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] p1_info,
  input  logic [3:0] p2_info,
  output logic [9:0] q_x1,
  output logic [9:0] q_y1,
  output logic [9:0] q_x2,
  output logic [9:0] q_y2,
  output logic       q_valid,
  input  logic       hit1,
  input  logic       hit2,
  output logic [9:0] x1,
  output logic [9:0] y1,
  output logic [9:0] x2,
  output logic [9:0] y2,
  output logic       trace_we,
  output logic       running,
  output logic [1:0] winner
);

  // Encoding chosen so that the reverse of a heading is heading ^ 1.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_CHECK  = 3'd2,
    S_COMMIT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] XMAX   = 11'(ARENA_W - 1);
  localparam logic [10:0] YMAX   = 11'(ARENA_H - 1);
  localparam logic [9:0]  P1X    = 10'(P1_X0);
  localparam logic [9:0]  P1Y    = 10'(P1_Y0);
  localparam logic [9:0]  P2X    = 10'(P2_X0);
  localparam logic [9:0]  P2Y    = 10'(P2_Y0);

  state_t      state_q;
  dir_t        dir1_q, dir2_q, dir1_d, dir2_d;
  logic [9:0]  x1_q, y1_q, x2_q, y2_q;
  logic [9:0]  q_x1_q, q_y1_q, q_x2_q, q_y2_q;
  logic        wall1_q, wall2_q;
  logic        q_valid_q, trace_we_q;
  logic [1:0]  winner_q;
  logic [20:0] adv1, adv2;
  logic        same_cell, head_swap, crash1, crash2;

  // Buttons with priority up>down>left>right; a reversal request keeps the heading.
  function automatic dir_t decode(input dir_t cur, input logic [3:0] info);
    dir_t req;
    if (info[3])      req = DIR_UP;
    else if (info[2]) req = DIR_DOWN;
    else if (info[1]) req = DIR_LEFT;
    else if (info[0]) req = DIR_RIGHT;
    else              req = cur;
    if (req == dir_t'(cur ^ 2'b01)) req = cur;
    return req;
  endfunction

  // Candidate next head {wall, x, y}; the sum is formed in 11 bits and clamped at the walls.
  function automatic logic [20:0] advance(input logic [9:0] x, input logic [9:0] y,
                                          input dir_t d);
    logic [10:0] xs, ys;
    logic [9:0]  nx, ny;
    logic        wall;
    xs   = {1'b0, x};
    ys   = {1'b0, y};
    nx   = x;
    ny   = y;
    wall = 1'b0;
    case (d)
      DIR_UP: begin
        if (ys < STEP_W) begin wall = 1'b1; ny = 10'd0; end
        else ny = 10'(ys - STEP_W);
      end
      DIR_DOWN: begin
        if (ys + STEP_W > YMAX) begin wall = 1'b1; ny = YMAX[9:0]; end
        else ny = 10'(ys + STEP_W);
      end
      DIR_LEFT: begin
        if (xs < STEP_W) begin wall = 1'b1; nx = 10'd0; end
        else nx = 10'(xs - STEP_W);
      end
      DIR_RIGHT: begin
        if (xs + STEP_W > XMAX) begin wall = 1'b1; nx = XMAX[9:0]; end
        else nx = 10'(xs + STEP_W);
      end
    endcase
    return {wall, nx, ny};
  endfunction

  // Next headings and candidate heads from the current registered state.
  always_comb begin
    dir1_d = decode(dir1_q, p1_info);
    dir2_d = decode(dir2_q, p2_info);
    adv1   = advance(x1_q, y1_q, dir1_q);
    adv2   = advance(x2_q, y2_q, dir2_q);
  end

  // Crash terms evaluated in CHECK against the latched candidates and the live hit answers.
  always_comb begin
    same_cell = (q_x1_q == q_x2_q) && (q_y1_q == q_y2_q);
    head_swap = (q_x1_q == x2_q) && (q_y1_q == y2_q) &&
                (q_x2_q == x1_q) && (q_y2_q == y1_q);
    crash1    = wall1_q | hit1 | same_cell | head_swap;
    crash2    = wall2_q | hit2 | same_cell | head_swap;
  end

  // Game state machine with registered heads, query, pulses and result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dir1_q     <= DIR_UP;
      dir2_q     <= DIR_DOWN;
      x1_q       <= P1X;
      y1_q       <= P1Y;
      x2_q       <= P2X;
      y2_q       <= P2Y;
      q_x1_q     <= P1X;
      q_y1_q     <= P1Y;
      q_x2_q     <= P2X;
      q_y2_q     <= P2Y;
      wall1_q    <= 1'b0;
      wall2_q    <= 1'b0;
      q_valid_q  <= 1'b0;
      trace_we_q <= 1'b0;
      winner_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          trace_we_q <= 1'b0;
          q_valid_q  <= 1'b0;
          if (start) begin
            state_q    <= S_RUN;
            trace_we_q <= 1'b1;
          end
        end
        S_RUN: begin
          trace_we_q <= 1'b0;
          dir1_q     <= dir1_d;
          dir2_q     <= dir2_d;
          if (tick) begin
            {wall1_q, q_x1_q, q_y1_q} <= adv1;
            {wall2_q, q_x2_q, q_y2_q} <= adv2;
            q_valid_q <= 1'b1;
            state_q   <= S_CHECK;
          end
        end
        S_CHECK: begin
          q_valid_q <= 1'b0;
          if (crash1 || crash2) begin
            winner_q <= {crash1, crash2};
            state_q  <= S_OVER;
          end else begin
            x1_q       <= q_x1_q;
            y1_q       <= q_y1_q;
            x2_q       <= q_x2_q;
            y2_q       <= q_y2_q;
            trace_we_q <= 1'b1;
            state_q    <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          trace_we_q <= 1'b0;
          state_q    <= S_RUN;
        end
        S_OVER: begin
          if (start) begin
            state_q  <= S_IDLE;
            dir1_q   <= DIR_UP;
            dir2_q   <= DIR_DOWN;
            x1_q     <= P1X;
            y1_q     <= P1Y;
            x2_q     <= P2X;
            y2_q     <= P2Y;
            q_x1_q   <= P1X;
            q_y1_q   <= P1Y;
            q_x2_q   <= P2X;
            q_y2_q   <= P2Y;
            winner_q <= 2'b00;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign q_x1     = q_x1_q;
  assign q_y1     = q_y1_q;
  assign q_x2     = q_x2_q;
  assign q_y2     = q_y2_q;
  assign q_valid  = q_valid_q;
  assign x1       = x1_q;
  assign y1       = y1_q;
  assign x2       = x2_q;
  assign y2       = y2_q;
  assign trace_we = trace_we_q;
  assign winner   = winner_q;
  assign running  = (state_q == S_RUN) || (state_q == S_CHECK) || (state_q == S_COMMIT);

endmodule
